// File: rtl/lemon_pkg.sv
// lemon_pkg: shared widths, zero-register index and writeback request type.
package lemon_pkg;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] rd;
        logic [DATA_WIDTH_DEF-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with rotating pointer, one-hot grant and grant index.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic [IW-1:0] ptr;

    // Scan from the farthest slot back to the pointer so the nearest request wins.
    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[IW'((int'(ptr) + k) % N)]) begin
                gnt_idx = IW'((int'(ptr) + k) % N);
                gnt = N'(1) << ((int'(ptr) + k) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (advance)
            ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port with
// a registered output stage and a per-register busy scoreboard.
module regfile_wb_arbiter
    import lemon_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REQ = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_rd,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic                           rf_wen,
    output logic [ADDR_WIDTH-1:0]          rf_rd,
    output logic [DATA_WIDTH-1:0]          rf_dataD,
    input  logic                           rsv_valid,
    input  logic [ADDR_WIDTH-1:0]          rsv_rd,
    input  logic [ADDR_WIDTH-1:0]          rs1,
    input  logic [ADDR_WIDTH-1:0]          rs2,
    output logic                           rs1_busy,
    output logic                           rs2_busy
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    gnt;
    logic [IW-1:0]         gnt_idx;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] win_rd;
    logic [DATA_WIDTH-1:0] win_data;
    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       set_mask;
    logic [NREG-1:0]       clr_mask;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (xfer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt & {NUM_REQ{rst_n}};
    assign xfer = |req_ready;
    assign win_rd = req_rd[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_data = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    // x0 transfers are consumed but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen <= 1'b0;
            rf_rd <= '0;
            rf_dataD <= '0;
        end else begin
            rf_wen <= xfer && (win_rd != ADDR_WIDTH'(ZERO_REG));
            if (xfer) begin
                rf_rd <= win_rd;
                rf_dataD <= win_data;
            end
        end
    end

    // Set is applied after clear so a same-edge reserve keeps the bit for the newer owner.
    assign set_mask = rsv_valid ? NREG'(1) << rsv_rd : '0;
    assign clr_mask = rf_wen ? NREG'(1) << rf_rd : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= ((busy & ~clr_mask) | set_mask) & ~NREG'(1);
    end

    assign rs1_busy = busy[rs1];
    assign rs2_busy = busy[rs2];
endmodule
